// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arbiter_if : fetch / data / memory bus bundle for mem_arbiter
// Revision 1.0
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
  parameter int ADDR = 16,
  parameter int WORD = 32
);
  logic            if_req_i;
  logic [ADDR-1:0] if_addr_i;
  logic            if_gnt_o;
  logic            if_rvalid_o;
  logic [WORD-1:0] if_rdata_o;
  logic            if_stall_o;

  logic            d_req_i;
  logic            d_we_i;
  logic [ADDR-1:0] d_addr_i;
  logic [WORD-1:0] d_wdata_i;
  logic            d_gnt_o;
  logic            d_rvalid_o;
  logic [WORD-1:0] d_rdata_o;

  logic [ADDR-1:0] mem_a_o;
  logic            mem_w_o;
  logic [WORD-1:0] mem_d_o;
  logic [WORD-1:0] mem_q_i;

  modport slave (
    input  if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_q_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o, if_stall_o,
           d_gnt_o, d_rvalid_o, d_rdata_o, mem_a_o, mem_w_o, mem_d_o
  );

  modport master (
    output if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_q_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o, if_stall_o,
           d_gnt_o, d_rvalid_o, d_rdata_o, mem_a_o, mem_w_o, mem_d_o
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arbiter : data-priority single-port memory arbiter with optional fetch
// starvation guard (MEMARB_STARVE_GUARD_EN).            Revision 1.0
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int STARVE_MAX = 3
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_IF   = 2'b01,
    OWN_D    = 2'b10
  } owner_t;

  owner_t r_owner;
  owner_t w_owner_nxt;
  logic   w_if_gnt;
  logic   w_d_gnt;
  logic   w_force;

  generate
    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_chk_starve
      $error("STARVE_MAX must be in 1..15");
    end
  endgenerate

`ifdef MEMARB_STARVE_GUARD_EN
  logic [3:0] r_guard_cnt;

  assign w_force = (r_guard_cnt == 4'(STARVE_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_guard_cnt <= 4'd0;
    end else if (!bus.if_req_i || w_if_gnt) begin
      r_guard_cnt <= 4'd0;
    end else if (r_guard_cnt != 4'(STARVE_MAX)) begin
      r_guard_cnt <= r_guard_cnt + 4'd1;
    end
  end
`else
  assign w_force = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= OWN_NONE;
    end else begin
      r_owner <= w_owner_nxt;
    end
  end

  always_comb begin
    w_if_gnt    = 1'b0;
    w_d_gnt     = 1'b0;
    w_owner_nxt = OWN_NONE;

    if (bus.if_req_i && w_force) begin
      w_if_gnt = 1'b1;
    end else if (bus.d_req_i) begin
      w_d_gnt = 1'b1;
    end else if (bus.if_req_i) begin
      w_if_gnt = 1'b1;
    end

    // Writes finish in the grant cycle, so only reads claim the return slot.
    if (w_if_gnt) begin
      w_owner_nxt = OWN_IF;
    end else if (w_d_gnt && !bus.d_we_i) begin
      w_owner_nxt = OWN_D;
    end
  end

  assign bus.if_gnt_o    = w_if_gnt;
  assign bus.d_gnt_o     = w_d_gnt;
  assign bus.if_stall_o  = bus.if_req_i & ~w_if_gnt;

  assign bus.mem_a_o     = w_d_gnt ? bus.d_addr_i  : bus.if_addr_i;
  assign bus.mem_w_o     = w_d_gnt & bus.d_we_i;
  assign bus.mem_d_o     = w_d_gnt ? bus.d_wdata_i : '0;

  assign bus.if_rvalid_o = (r_owner == OWN_IF);
  assign bus.d_rvalid_o  = (r_owner == OWN_D);
  assign bus.if_rdata_o  = bus.mem_q_i;
  assign bus.d_rdata_o   = bus.mem_q_i;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_arbiter : directed stimulus with a read-return scoreboard
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  logic clk;
  logic rst_n;

  mem_arbiter_if #(.ADDR(16), .WORD(32)) bus ();

  mem_arbiter #(.STARVE_MAX(3)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory model: Q presents the addressed word one cycle later.
  logic [31:0] mem [0:65535];
  always @(posedge clk) begin
    if (bus.mem_w_o) mem[bus.mem_a_o] <= bus.mem_d_o;
    bus.mem_q_i <= mem[bus.mem_a_o];
  end

  typedef struct {
    bit          is_if;
    logic [31:0] data;
  } rd_t;

  rd_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input bit is_if, input logic [31:0] data);
    rd_t e;
    e.is_if = is_if;
    e.data  = data;
    exp_q.push_back(e);
  endtask

  // Monitor: every rvalid must match the oldest outstanding read.
  always @(negedge clk) begin
    if (bus.if_rvalid_o && bus.d_rvalid_o) begin
      checks++;
      errors++;
      $display("FAIL both_rvalid: got if=1 d=1, expected at most one");
    end else if (bus.if_rvalid_o || bus.d_rvalid_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rvalid: got if=%0b d=%0b, expected none",
                 bus.if_rvalid_o, bus.d_rvalid_o);
      end else begin
        rd_t e;
        e = exp_q.pop_front();
        if (e.is_if != bus.if_rvalid_o) begin
          errors++;
          $display("FAIL rvalid_owner: got if_rvalid=%0b, expected %0b",
                   bus.if_rvalid_o, e.is_if);
        end else if ((e.is_if ? bus.if_rdata_o : bus.d_rdata_o) !== e.data) begin
          errors++;
          $display("FAIL rdata: got %h, expected %h",
                   e.is_if ? bus.if_rdata_o : bus.d_rdata_o, e.data);
        end
      end
    end
  end

  // Drive one cycle of inputs just after the edge, then wait to sample.
  task automatic cyc(input logic ir, input logic [15:0] ia, input logic dr,
                     input logic dw, input logic [15:0] da, input logic [31:0] dd);
    @(posedge clk);
    #1;
    bus.if_req_i  = ir;
    bus.if_addr_i = ia;
    bus.d_req_i   = dr;
    bus.d_we_i    = dw;
    bus.d_addr_i  = da;
    bus.d_wdata_i = dd;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  n_if;
    bit  exp_if;

    mem[16'h0010] = 32'hDEADBEEF;
    mem[16'h0040] = 32'hCAFEF00D;

    // Reset held with both requests high.
    rst_n         = 1'b0;
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 16'h0010;
    bus.d_req_i   = 1'b1;
    bus.d_we_i    = 1'b0;
    bus.d_addr_i  = 16'h0040;
    bus.d_wdata_i = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_if_rvalid", {31'b0, bus.if_rvalid_o}, 32'd0);
    chk("rst_d_rvalid",  {31'b0, bus.d_rvalid_o},  32'd0);
    chk("rst_d_gnt",     {31'b0, bus.d_gnt_o},     32'd1);

    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_d_gnt",  {31'b0, bus.d_gnt_o},  32'd1);
    chk("post_rst_if_gnt", {31'b0, bus.if_gnt_o}, 32'd0);
    push(1'b0, 32'hCAFEF00D);

    // Fetch alone.
    cyc(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 32'h0);
    chk("fetch_gnt",   {31'b0, bus.if_gnt_o},   32'd1);
    chk("fetch_addr",  {16'b0, bus.mem_a_o},    32'h0010);
    chk("fetch_stall", {31'b0, bus.if_stall_o}, 32'd0);
    chk("fetch_mem_w", {31'b0, bus.mem_w_o},    32'd0);
    push(1'b1, 32'hDEADBEEF);

    // Data write collides with a fetch of the same address.
    cyc(1'b1, 16'h0020, 1'b1, 1'b1, 16'h0020, 32'h12345678);
    chk("wr_d_gnt",  {31'b0, bus.d_gnt_o},    32'd1);
    chk("wr_stall",  {31'b0, bus.if_stall_o}, 32'd1);
    chk("wr_mem_w",  {31'b0, bus.mem_w_o},    32'd1);
    chk("wr_mem_d",  bus.mem_d_o,             32'h12345678);
    cyc(1'b1, 16'h0020, 1'b0, 1'b0, 16'h0, 32'h0);
    chk("wr_then_fetch_gnt", {31'b0, bus.if_gnt_o}, 32'd1);
    push(1'b1, 32'h12345678);

    cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    chk("idle_gnt", {30'b0, bus.if_gnt_o, bus.d_gnt_o}, 32'd0);

    // Continuous contention for 12 cycles.
    n_if = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0040, 32'h0);
`ifdef MEMARB_STARVE_GUARD_EN
      exp_if = ((i % 4) == 3);
`else
      exp_if = 1'b0;
`endif
      chk($sformatf("starve_if_gnt_c%0d", i + 1), {31'b0, bus.if_gnt_o}, {31'b0, exp_if});
      chk($sformatf("starve_d_gnt_c%0d",  i + 1), {31'b0, bus.d_gnt_o},  {31'b0, ~exp_if});
      if (bus.if_gnt_o) n_if++;
      if (exp_if) push(1'b1, 32'hDEADBEEF);
      else        push(1'b0, 32'hCAFEF00D);
    end
`ifdef MEMARB_STARVE_GUARD_EN
    chk("starve_if_count", n_if, 32'd3);
`else
    chk("starve_if_count", n_if, 32'd0);
`endif
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0);

    // Reset lands between a data-read grant and its return.
    cyc(1'b0, 16'h0, 1'b1, 1'b0, 16'h0040, 32'h0);
    chk("midrd_d_gnt", {31'b0, bus.d_gnt_o}, 32'd1);
    rst_n       = 1'b0;
    bus.d_req_i = 1'b0;
    @(posedge clk);
    #1;
    chk("midrd_rvalid_in_rst", {31'b0, bus.d_rvalid_o}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrd_rvalid_after", {30'b0, bus.if_rvalid_o, bus.d_rvalid_o}, 32'd0);

    // Single write produces no return.
    cyc(1'b0, 16'h0, 1'b1, 1'b1, 16'h0030, 32'hA5A5A5A5);
    chk("wr30_mem_w", {31'b0, bus.mem_w_o}, 32'd1);
    chk("wr30_mem_a", {16'b0, bus.mem_a_o}, 32'h0030);
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    chk("wr30_no_rvalid", {30'b0, bus.if_rvalid_o, bus.d_rvalid_o}, 32'd0);

    repeat (3) cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter that shares one 32-bit × 64K synchronous memory between the instruction-fetch stage and the load/store (data) stage. Each cycle it grants at most one requester, drives the memory address, write-enable and write-data lines, and routes the read data back to the winner one cycle later. Data accesses have priority. A starvation guard forces a fetch grant after a bounded number of consecutive fetch losses. It sits between `ifetch`, the load/store unit and `DP_mem32x64k`.

## Interface

- `ADDR`, 16, address width (from `include/params.vh`)
- `WORD`, 32, data width (from `include/params.vh`)
- `STARVE_MAX`, 3, consecutive fetch losses before fetch is forced (1..15)

- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `if_req_i`  in  1  fetch read request
- `if_addr_i`  in  ADDR  fetch address
- `if_gnt_o`  out  1  fetch granted this cycle (combinational)
- `if_rvalid_o`  out  1  fetch read data valid (registered)
- `if_rdata_o`  out  WORD  fetch read data
- `if_stall_o`  out  1  `if_req_i & ~if_gnt_o`; feeds `ifetch` `stall_i`
- `d_req_i`  in  1  data request
- `d_we_i`  in  1  1 = write, 0 = read
- `d_addr_i`  in  ADDR  data address
- `d_wdata_i`  in  WORD  write data
- `d_gnt_o`  out  1  data granted this cycle (combinational)
- `d_rvalid_o`  out  1  data read data valid (registered)
- `d_rdata_o`  out  WORD  data read data
- `mem_a_o`  out  ADDR  to memory `A`
- `mem_w_o`  out  1  to memory `W`
- `mem_d_o`  out  WORD  to memory `D`
- `mem_q_i`  in  WORD  from memory `Q`; valid one cycle after `A`

## Operation

- Grant is decided combinationally each cycle. The rule is evaluated in this order:
  - `force = guard_cnt == STARVE_MAX` (guard enabled only)
  - if `if_req_i & force`, grant fetch
  - else if `d_req_i`, grant data
  - else if `if_req_i`, grant fetch
  - else grant nothing
- Memory drive:
  - Data granted: `mem_a_o = d_addr_i`, `mem_w_o = d_we_i`, `mem_d_o = d_wdata_i`.
  - Otherwise: `mem_a_o = if_addr_i`, `mem_w_o = 0`, `mem_d_o = 0`.
- Read return is registered. `owner` is a 2-bit register with one-hot values IF, D or NONE.
  - `owner` is set to IF on a fetch grant, to D on a data read grant, and to NONE otherwise. A data write sets NONE.
  - `if_rvalid_o = (owner == IF)` and `d_rvalid_o = (owner == D)`.
  - Both `if_rdata_o` and `d_rdata_o` are driven by `mem_q_i`. They are qualified only by their rvalid.
- Writes complete in the grant cycle and produce no rvalid.
- Starvation guard `guard_cnt` is a 4-bit counter:
  - increments when `if_req_i & ~if_gnt_o`
  - clears when fetch is granted or `if_req_i` is low
  - saturates at `STARVE_MAX`
- Requesters hold their request and address until they see the grant. The arbiter does not latch requests.

## Timing

- Reset (`rst` low, asynchronous): `owner` = NONE, `guard_cnt` = 0, `if_rvalid_o` = 0, `d_rvalid_o` = 0.
- Combinational outputs during reset follow the inputs with `guard_cnt` = 0.
- Reset asserted with a read in flight drops that read. No rvalid follows deassertion.
- Grant is issued in cycle N with zero latency. Read data and rvalid appear in cycle N+1.
- Back-to-back grants are allowed every cycle, giving full throughput of one access per cycle.
- Simultaneous `if_req_i` and `d_req_i`: data wins unless `force`.
- Under continuous `d_req_i` with STARVE_MAX=3, fetch wins every 4th cycle.
- At most one rvalid is high per cycle.

## Configuration

- `MEMARB_STARVE_GUARD_EN` defined: the starvation guard is present, as described above.
- Not defined: `guard_cnt` is removed and `force` is tied to 0. This gives strict data priority, and fetch can starve indefinitely under continuous data traffic.

## Test plan

- Reset: hold `rst`=0 with both requests high. Expect both rvalids = 0. After release, the first grant goes to data and `d_rvalid_o`=1 one cycle later.
- Fetch alone: `if_req_i`=1, `if_addr_i`=0x0010, memory preloaded with 0xDEADBEEF at 0x0010. Expect `if_gnt_o`=1 and `mem_a_o`=0x0010. Next cycle expect `if_rvalid_o`=1 and `if_rdata_o`=0xDEADBEEF.
- Data write then fetch of the same address: write 0x12345678 to 0x0020 while `if_req_i`=1 at 0x0020. Expect data granted and `if_stall_o`=1. Next cycle expect the fetch granted and, one cycle later, `if_rdata_o`=0x12345678.
- Starvation, guard enabled, STARVE_MAX=3: hold `d_req_i` and `if_req_i` high for 12 cycles. Expect the fetch grant in cycles 4, 8 and 12 and data grants in the rest. With the macro undefined, expect 0 fetch grants.
- Reset mid-read: grant a data read, then assert `rst` before the next edge. Expect `d_rvalid_o` to stay 0.
- Write produces no rvalid: a single data write with `d_we_i`=1 to 0x0030. Expect `mem_w_o`=1 in the grant cycle and both rvalids 0 in the following cycle.
